ysyx_25060170_sram: RTL and testbench

- AXI4-Lite memory responder (slave) holding program/data words.
- It is the target end of the fetch/load-store interface. IFU and LSU become initiators against it, replacing the combinational instruction memory.
- Independent read and write channels. Each channel has a per-transaction latency counter, optionally randomised by an LFSR, to stress initiator handshakes.

---
 rtl/ysyx_25060170_axi_pkg.sv | 39 +++
 rtl/ysyx_25060170_lfsr.sv | 30 +++
 rtl/ysyx_25060170_sram.sv | 216 +++++++++++++++++++++
 tb/tb_ysyx_25060170_sram.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_25060170_axi_pkg.sv
// Shared AXI4-Lite responder definitions: response codes, FSM states,
// LFSR constants and the latency-counter load helper.
package ysyx_25060170_axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    R_IDLE,
    R_WAIT,
    R_RESP
  } r_state_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_WAIT,
    W_RESP
  } w_state_e;

  localparam int unsigned LFSR_W    = 8;
  localparam logic [7:0]  LFSR_SEED = 8'hA5;
  // x^8+x^6+x^5+x^4+1 taps on bits 7,5,4,3 of a left-shifting register
  localparam logic [7:0]  LFSR_TAPS = 8'b1011_1000;

  localparam int unsigned CNT_W   = 4;
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

  // A latency of 0 behaves as 1; the sum saturates so the counter never wraps.
  function automatic logic [CNT_W-1:0] lat_load(input int unsigned lat,
                                                input logic [2:0]  extra,
                                                input bit          en);
    int unsigned sum;
    sum = (lat > 1) ? lat - 1 : 0;
    if (en) sum = sum + {29'd0, extra};
    if (sum > CNT_MAX) sum = CNT_MAX;
    return CNT_W'(sum);
  endfunction

endpackage

// File: rtl/ysyx_25060170_lfsr.sv
// 8-bit Fibonacci LFSR used to jitter responder latencies; the low OUT_W
// bits are exported so each user takes only the randomness it needs.
module ysyx_25060170_lfsr
  import ysyx_25060170_axi_pkg::*;
#(
  parameter int unsigned OUT_W = LFSR_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [OUT_W-1:0] rnd
);

  logic [LFSR_W-1:0] lfsr_q, lfsr_d;

  // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    lfsr_d = lfsr_q;
    if (en) lfsr_d = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & LFSR_TAPS)};
  end

  // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= LFSR_SEED;
    else        lfsr_q <= lfsr_d;
  end

  assign rnd = lfsr_q[OUT_W-1:0];

endmodule

// File: rtl/ysyx_25060170_sram.sv
// AXI4-Lite memory responder with independent read and write channels, each
// with a programmable (optionally LFSR-jittered) response latency.
module ysyx_25060170_sram
  import ysyx_25060170_axi_pkg::*;
#(
  parameter int unsigned       ADDR_W     = 32,
  parameter int unsigned       DATA_W     = 32,
  parameter int unsigned       DEPTH_LOG2 = 12,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = 32'h8000_0000,
  parameter int unsigned       RD_LAT     = 1,
  parameter int unsigned       WR_LAT     = 1,
  parameter bit                LFSR_EN    = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   araddr,
  input  logic                arvalid,
  output logic                arready,
  output logic [DATA_W-1:0]   rdata,
  output logic [1:0]          rresp,
  output logic                rvalid,
  input  logic                rready,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic                awvalid,
  output logic                awready,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wvalid,
  output logic                wready,
  output logic [1:0]          bresp,
  output logic                bvalid,
  input  logic                bready
);

  localparam int unsigned DEPTH  = 1 << DEPTH_LOG2;
  localparam int unsigned STRB_W = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [2:0]       lfsr_extra;
  logic [CNT_W-1:0] rd_load, wr_load;

  ysyx_25060170_lfsr #(.OUT_W(3)) u_lfsr (
    .clk   (clk),
    .rst_n (rst),
    .en    (1'b1),
    .rnd   (lfsr_extra)
  );

  assign rd_load = lat_load(RD_LAT, lfsr_extra, LFSR_EN);
  assign wr_load = lat_load(WR_LAT, lfsr_extra, LFSR_EN);

  function automatic logic addr_mapped(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] offset;
    offset = a - BASE_ADDR;
    return (a >= BASE_ADDR) && ((offset >> (DEPTH_LOG2 + 2)) == '0);
  endfunction

  function automatic logic [DEPTH_LOG2-1:0] word_idx(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] offset;
    offset = a - BASE_ADDR;
    return DEPTH_LOG2'(offset >> 2);
  endfunction

  // ---------------- read channel ----------------
  r_state_e          r_state_q, r_state_d;
  logic [CNT_W-1:0]  r_cnt_q, r_cnt_d;
  logic [ADDR_W-1:0] r_addr_q, r_addr_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;

  always_comb begin
    r_state_d = r_state_q;
    r_cnt_d   = r_cnt_q;
    r_addr_d  = r_addr_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    unique case (r_state_q)
      R_IDLE: if (arvalid) begin
        r_addr_d  = araddr;
        r_cnt_d   = rd_load;
        r_state_d = R_WAIT;
      end
      R_WAIT: begin
        if (r_cnt_q == '0) begin
          // A write committing this same edge is not yet visible, so the old word is returned.
          if (addr_mapped(r_addr_q)) begin
            rdata_d = mem[word_idx(r_addr_q)];
            rresp_d = RESP_OKAY;
          end else begin
            rdata_d = '0;
            rresp_d = RESP_SLVERR;
          end
          r_state_d = R_RESP;
        end else begin
          r_cnt_d = r_cnt_q - 1'b1;
        end
      end
      R_RESP: if (rready) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state_q <= R_IDLE;
      r_cnt_q   <= '0;
      r_addr_q  <= '0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      r_state_q <= r_state_d;
      r_cnt_q   <= r_cnt_d;
      r_addr_q  <= r_addr_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  assign arready = (r_state_q == R_IDLE);
  assign rvalid  = (r_state_q == R_RESP);
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;

  // ---------------- write channel ----------------
  w_state_e          w_state_q, w_state_d;
  logic [CNT_W-1:0]  w_cnt_q, w_cnt_d;
  logic              aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [ADDR_W-1:0] w_addr_q, w_addr_d;
  logic [DATA_W-1:0] w_data_q, w_data_d;
  logic [STRB_W-1:0] w_strb_q, w_strb_d;
  logic [1:0]        bresp_q, bresp_d;
  logic              aw_fire, w_fire, mem_we;

  assign awready = (w_state_q == W_IDLE) && !aw_held_q;
  assign wready  = (w_state_q == W_IDLE) && !w_held_q;
  assign aw_fire = awvalid && awready;
  assign w_fire  = wvalid && wready;

  always_comb begin
    w_state_d = w_state_q;
    w_cnt_d   = w_cnt_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    w_addr_d  = w_addr_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    bresp_d   = bresp_q;
    mem_we    = 1'b0;
    unique case (w_state_q)
      W_IDLE: begin
        if (aw_fire) begin
          w_addr_d  = awaddr;
          aw_held_d = 1'b1;
        end
        if (w_fire) begin
          w_data_d = wdata;
          w_strb_d = wstrb;
          w_held_d = 1'b1;
        end
        if ((aw_held_q || aw_fire) && (w_held_q || w_fire)) begin
          w_cnt_d   = wr_load;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          w_state_d = W_WAIT;
        end
      end
      W_WAIT: begin
        if (w_cnt_q == '0) begin
          mem_we    = addr_mapped(w_addr_q);
          bresp_d   = addr_mapped(w_addr_q) ? RESP_OKAY : RESP_SLVERR;
          w_state_d = W_RESP;
        end else begin
          w_cnt_d = w_cnt_q - 1'b1;
        end
      end
      W_RESP: if (bready) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_state_q <= W_IDLE;
      w_cnt_q   <= '0;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      w_addr_q  <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bresp_q   <= RESP_OKAY;
    end else begin
      w_state_q <= w_state_d;
      w_cnt_q   <= w_cnt_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      w_addr_q  <= w_addr_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      bresp_q   <= bresp_d;
    end
  end

  // NOTE: the storage array has no reset; a reset only stops the FSM, so mem_we stays low.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (w_strb_q[b]) mem[word_idx(w_addr_q)][8*b +: 8] <= w_data_q[8*b +: 8];
      end
    end
  end

  assign bvalid = (w_state_q == W_RESP);
  assign bresp  = bresp_q;

endmodule

// File: tb/tb_ysyx_25060170_sram.sv
// Scoreboard bench: drivers push expected R/B responses, a negedge monitor
// pops and compares on every handshake. Instance 0 fixed latency, 1 jittered.
module tb_ysyx_25060170_sram;
  import ysyx_25060170_axi_pkg::*;

  localparam logic [31:0] BASE = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] araddr [2];
  logic        arvalid[2], arready[2];
  logic [31:0] rdata  [2];
  logic [1:0]  rresp  [2];
  logic        rvalid [2], rready [2];
  logic [31:0] awaddr [2];
  logic        awvalid[2], awready[2];
  logic [31:0] wdata  [2];
  logic [3:0]  wstrb  [2];
  logic        wvalid [2], wready [2];
  logic [1:0]  bresp  [2];
  logic        bvalid [2], bready [2];

  always #5 clk = ~clk;

  ysyx_25060170_sram u_dut (
    .clk(clk), .rst(rst),
    .araddr(araddr[0]), .arvalid(arvalid[0]), .arready(arready[0]),
    .rdata(rdata[0]), .rresp(rresp[0]), .rvalid(rvalid[0]), .rready(rready[0]),
    .awaddr(awaddr[0]), .awvalid(awvalid[0]), .awready(awready[0]),
    .wdata(wdata[0]), .wstrb(wstrb[0]), .wvalid(wvalid[0]), .wready(wready[0]),
    .bresp(bresp[0]), .bvalid(bvalid[0]), .bready(bready[0])
  );

  ysyx_25060170_sram #(.LFSR_EN(1'b1)) u_dut_rnd (
    .clk(clk), .rst(rst),
    .araddr(araddr[1]), .arvalid(arvalid[1]), .arready(arready[1]),
    .rdata(rdata[1]), .rresp(rresp[1]), .rvalid(rvalid[1]), .rready(rready[1]),
    .awaddr(awaddr[1]), .awvalid(awvalid[1]), .awready(awready[1]),
    .wdata(wdata[1]), .wstrb(wstrb[1]), .wvalid(wvalid[1]), .wready(wready[1]),
    .bresp(bresp[1]), .bvalid(bvalid[1]), .bready(bready[1])
  );

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } rd_exp_t;

  rd_exp_t    rd_q[$];
  logic [1:0] wr_q[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [31:0] model[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_range(input string name, input int v, input int lo, input int hi);
    n_tests++;
    if (v < lo || v > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d..%0d (t=%0t)", name, v, lo, hi, $time);
    end
  endtask

  // Monitor: a valid&ready seen at negedge completes on the next rising edge.
  always @(negedge clk) begin
    rd_exp_t    re;
    logic [1:0] be;
    for (int s = 0; s < 2; s++) begin
      if (rvalid[s] === 1'b1 && rready[s] === 1'b1) begin
        if (rd_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL r_unexpected: got R beat on dut %0d expected none", s);
        end else begin
          re = rd_q.pop_front();
          check("r_data", rdata[s], re.data);
          check("r_resp", 32'(rresp[s]), 32'(re.resp));
        end
      end
      if (bvalid[s] === 1'b1 && bready[s] === 1'b1) begin
        if (wr_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL b_unexpected: got B beat on dut %0d expected none", s);
        end else begin
          be = wr_q.pop_front();
          check("b_resp", 32'(bresp[s]), 32'(be));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // hold = cycles rready stays low once rvalid is up (0: rready high from the start).
  task automatic do_read(input int s, input logic [31:0] addr, input logic [31:0] exp_data,
                         input logic [1:0] exp_resp, input int max_lat, input int hold);
    int n, lat;
    logic [31:0] d0;
    rd_q.push_back('{data: exp_data, resp: exp_resp});
    araddr[s] = addr; arvalid[s] = 1'b1; rready[s] = (hold == 0);
    n = 0;
    while (!arready[s] && n < 50) begin step(); n++; end
    check_range("ar_wait", n, 0, 49);
    step();
    arvalid[s] = 1'b0;
    lat = 0;
    while (!rvalid[s] && lat < 40) begin step(); lat++; end
    check_range("r_latency", lat, 1, max_lat);
    d0 = rdata[s];
    for (int i = 0; i < hold; i++) begin
      check("r_hold_rvalid", 32'(rvalid[s]), 32'd1);
      check("r_hold_rdata", rdata[s], d0);
      check("r_hold_arready", 32'(arready[s]), 32'd0);
      step();
    end
    rready[s] = 1'b1;
    step();
    rready[s] = 1'b0;
    check("r_done_rvalid", 32'(rvalid[s]), 32'd0);
  endtask

  // lead > 0: W presented lead cycles before AW; lead < 0: AW first.
  task automatic do_write(input int s, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input logic [1:0] exp_resp,
                          input int lead, input int max_lat, input int hold);
    int t, lat, aw_start, w_start;
    bit aw_done, w_done, aw_hs, w_hs;
    logic [1:0] b0;
    wr_q.push_back(exp_resp);
    aw_start = (lead > 0) ? lead : 0;
    w_start  = (lead < 0) ? -lead : 0;
    awaddr[s] = addr; wdata[s] = data; wstrb[s] = strb; bready[s] = (hold == 0);
    t = 0; aw_done = 1'b0; w_done = 1'b0;
    while (!(aw_done && w_done) && t < 60) begin
      awvalid[s] = !aw_done && (t >= aw_start);
      wvalid[s]  = !w_done && (t >= w_start);
      aw_hs = awvalid[s] && awready[s];
      w_hs  = wvalid[s] && wready[s];
      step(); t++;
      aw_done |= aw_hs;
      w_done  |= w_hs;
      if (w_done && !aw_done) check("w_ready_after_capture", 32'(wready[s]), 32'd0);
      if (aw_done && !w_done) check("aw_ready_after_capture", 32'(awready[s]), 32'd0);
    end
    awvalid[s] = 1'b0; wvalid[s] = 1'b0;
    check_range("aw_w_capture_cycles", t, 1, 59);
    lat = 0;
    while (!bvalid[s] && lat < 40) begin step(); lat++; end
    check_range("b_latency", lat, 1, max_lat);
    b0 = bresp[s];
    for (int i = 0; i < hold; i++) begin
      check("b_hold_bvalid", 32'(bvalid[s]), 32'd1);
      check("b_hold_bresp", 32'(bresp[s]), 32'(b0));
      check("b_hold_awready", 32'(awready[s]), 32'd0);
      check("b_hold_wready", 32'(wready[s]), 32'd0);
      step();
    end
    bready[s] = 1'b1;
    step();
    bready[s] = 1'b0;
    check("b_done_bvalid", 32'(bvalid[s]), 32'd0);
    check("b_done_awready", 32'(awready[s]), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish before 1ms");
    $fatal(1, "watchdog");
  end

  initial begin
    int         idx, lead, hold;
    logic [31:0] d;
    logic [3:0]  st;
    for (int s = 0; s < 2; s++) begin
      araddr[s] = '0; arvalid[s] = 1'b0; rready[s] = 1'b0;
      awaddr[s] = '0; awvalid[s] = 1'b0; wdata[s] = '0; wstrb[s] = '0;
      wvalid[s] = 1'b0; bready[s] = 1'b0;
    end
    step(); step();
    check("rst_arready", 32'(arready[0]), 32'd1);
    check("rst_awready", 32'(awready[0]), 32'd1);
    check("rst_wready",  32'(wready[0]),  32'd1);
    check("rst_rvalid",  32'(rvalid[0]),  32'd0);
    check("rst_bvalid",  32'(bvalid[0]),  32'd0);
    check("rst_rdata",   rdata[0],        32'd0);
    check("rst_rresp",   32'(rresp[0]),   32'd0);
    check("rst_bresp",   32'(bresp[0]),   32'd0);
    rst = 1'b1;
    step();

    // Fixed latency 1: rvalid/bvalid up on the edge after the handshake edge.
    do_write(0, BASE,        32'hDEAD_BEEF, 4'hF, RESP_OKAY, 0, 1, 0);
    do_write(0, BASE + 4,    32'hFFFF_FFFF, 4'hF, RESP_OKAY, 0, 1, 0);
    do_read (0, BASE,        32'hDEAD_BEEF, RESP_OKAY, 1, 0);
    do_write(0, BASE + 4,    32'h1122_3344, 4'b0101, RESP_OKAY, 0, 1, 0);
    do_read (0, BASE + 4,    32'hFF22_FF44, RESP_OKAY, 1, 0);
    do_write(0, BASE + 8,    32'hCAFE_F00D, 4'hF, RESP_OKAY, 3, 1, 4);
    do_read (0, BASE + 8,    32'hCAFE_F00D, RESP_OKAY, 1, 0);
    do_write(0, BASE + 12,   32'h0000_1234, 4'hF, RESP_OKAY, -2, 1, 0);
    do_read (0, BASE + 15,   32'h0000_1234, RESP_OKAY, 1, 0);
    do_write(0, BASE,        32'h5555_5555, 4'h0, RESP_OKAY, 0, 1, 0);
    do_read (0, 32'h7FFF_FFFC, 32'h0, RESP_SLVERR, 1, 0);
    do_write(0, 32'h8001_0000, 32'hAAAA_AAAA, 4'hF, RESP_SLVERR, 0, 1, 0);
    do_read (0, 32'h8001_0000, 32'h0, RESP_SLVERR, 1, 0);
    do_read (0, BASE,        32'hDEAD_BEEF, RESP_OKAY, 1, 0);
    do_write(0, BASE + 32'h3FFC, 32'h1234_5678, 4'hF, RESP_OKAY, 0, 1, 0);
    do_read (0, BASE + 32'h3FFC, 32'h1234_5678, RESP_OKAY, 1, 0);
    do_read (0, BASE + 4,    32'hFF22_FF44, RESP_OKAY, 1, 5);

    // Reset while both channels are waiting: no response, no memory write.
    do_write(0, BASE + 16,   32'h0000_0001, 4'hF, RESP_OKAY, 0, 1, 0);
    araddr[0] = BASE; arvalid[0] = 1'b1; rready[0] = 1'b1; bready[0] = 1'b1;
    awaddr[0] = BASE + 16; wdata[0] = 32'h0000_0002; wstrb[0] = 4'hF;
    awvalid[0] = 1'b1; wvalid[0] = 1'b1;
    step();
    arvalid[0] = 1'b0; awvalid[0] = 1'b0; wvalid[0] = 1'b0;
    check("rwait_arready", 32'(arready[0]), 32'd0);
    rst = 1'b0;
    #1;
    check("abort_arready", 32'(arready[0]), 32'd1);
    check("abort_rvalid",  32'(rvalid[0]),  32'd0);
    step(); step();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("abort_no_rvalid", 32'(rvalid[0]), 32'd0);
      check("abort_no_bvalid", 32'(bvalid[0]), 32'd0);
    end
    rready[0] = 1'b0; bready[0] = 1'b0;
    do_read (0, BASE + 16,   32'h0000_0001, RESP_OKAY, 1, 0);
    do_read (0, BASE,        32'hDEAD_BEEF, RESP_OKAY, 1, 0);

    // Jittered instance: every latency must land in 1..8.
    for (int i = 0; i < 8; i++) begin
      model[i] = $urandom;
      do_write(1, BASE + 4*i, model[i], 4'hF, RESP_OKAY, 0, 8, 0);
    end
    for (int n = 0; n < 100; n++) begin
      idx  = $urandom_range(0, 7);
      hold = $urandom_range(0, 2);
      if ($urandom_range(0, 1) == 1) begin
        d    = $urandom;
        st   = 4'($urandom_range(0, 15));
        lead = $urandom_range(0, 4) - 2;
        for (int b = 0; b < 4; b++) if (st[b]) model[idx][8*b +: 8] = d[8*b +: 8];
        do_write(1, BASE + 4*idx, d, st, RESP_OKAY, lead, 8, hold);
      end else begin
        do_read(1, BASE + 4*idx + $urandom_range(0, 3), model[idx], RESP_OKAY, 8, hold);
      end
    end

    // Same-edge AR and AW/W share the LFSR value, so the read samples as the write commits.
    fork
      do_read (1, BASE + 12, model[3], RESP_OKAY, 8, 0);
      do_write(1, BASE + 12, 32'h0BAD_F00D, 4'hF, RESP_OKAY, 0, 8, 0);
    join
    model[3] = 32'h0BAD_F00D;
    do_read(1, BASE + 12, model[3], RESP_OKAY, 8, 0);

    step(); step();
    check("rd_queue_drained", 32'(rd_q.size()), 32'd0);
    check("wr_queue_drained", 32'(wr_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
